// File: rtl/arbiter_rr_n_buffered.sv
// N-way round-robin arbiter feeding a 2-entry registered output buffer.
// in_ready is a function of in_valid, the priority pointer and buffer
// occupancy only, so the sink's out_ready never reaches the requesters
// combinationally.
module arbiter_rr_n_buffered #(
    parameter  int unsigned DWIDTH = 16,
    parameter  int unsigned N      = 2,
    localparam int unsigned ID_W   = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N-1:0]               in_valid,
    input  logic [N-1:0][DWIDTH-1:0]   in_data,
    output logic [N-1:0]               in_ready,
    output logic                       out_valid,
    output logic [DWIDTH-1:0]          out_data,
    output logic [ID_W-1:0]            out_id,
    input  logic                       out_ready
);

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic [ID_W-1:0]   id;
    } entry_t;

    logic [ID_W-1:0] ptr, ptr_n;
    logic [1:0]      count, count_n;
    entry_t          entry0, entry0_n;
    entry_t          entry1, entry1_n;
    entry_t          new_entry;

    logic [ID_W-1:0] gnt_idx;
    logic            gnt_valid;
    logic [ID_W-1:0] cand;
    logic            push;
    logic            pop;

    // Rotating-priority search: first valid requester starting at ptr.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = ID_W'((32'(ptr) + k) % N);
            if (!gnt_valid && in_valid[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Grant is issued only while the buffer has room and reset is low.
    always_comb begin
        in_ready = '0;
        push     = gnt_valid && (count != 2'd2) && !reset;
        if (push) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    assign pop       = out_valid && out_ready;
    assign new_entry = '{data: in_data[gnt_idx], id: gnt_idx};

    // Buffer occupancy, entry shifting and pointer advance.
    always_comb begin
        count_n  = count;
        entry0_n = entry0;
        entry1_n = entry1;
        ptr_n    = ptr;
        case (count)
            2'd0: begin
                if (push) begin
                    entry0_n = new_entry;
                    count_n  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    entry0_n = new_entry;
                end else if (push) begin
                    entry1_n = new_entry;
                    count_n  = 2'd2;
                end else if (pop) begin
                    count_n  = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    entry0_n = entry1;
                    count_n  = 2'd1;
                end
            end
            default: count_n = 2'd0;
        endcase
        if (push) begin
            ptr_n = (gnt_idx == ID_W'(N - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    // State registers; buffered words are discarded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            count     <= 2'd0;
            entry0    <= '0;
            entry1    <= '0;
            out_valid <= 1'b0;
        end else begin
            ptr       <= ptr_n;
            count     <= count_n;
            entry0    <= entry0_n;
            entry1    <= entry1_n;
            out_valid <= (count_n != 2'd0);
        end
    end

    assign out_data = entry0.data;
    assign out_id   = entry0.id;

endmodule

// File: tb/tb_arbiter_rr_n_buffered.sv
// Bench for arbiter_rr_n_buffered (N=4): directed vectors feed an expected
// queue; a negedge monitor pops and compares each accepted output word.
module tb_arbiter_rr_n_buffered;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          in_valid;
    logic [N-1:0][DW-1:0]  in_data;
    logic [N-1:0]          in_ready;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic [IW-1:0]         out_id;
    logic                  out_ready;

    arbiter_rr_n_buffered #(.DWIDTH(DW), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    exp_t          dq[$];
    logic [DW-1:0] rq[N][$];
    bit            rand_mode = 1'b0;
    exp_t          mon_e;
    logic [DW-1:0] mon_w;
    logic [N-1:0]  acc;
    int            seq[N];
    int            wait_cnt[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input int id, input logic [DW-1:0] data);
        dq.push_back('{id: IW'(id), data: data});
    endtask

    // Monitor: compare each word the sink takes against the expected queue.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (rand_mode) begin
                if (rq[out_id].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_unexpected actual=%0h required=none id=%0d", out_data, out_id);
                end else begin
                    mon_w = rq[out_id].pop_front();
                    chk("rand_word", 32'(out_data), 32'(mon_w));
                end
            end else begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", out_data);
                end else begin
                    mon_e = dq.pop_front();
                    chk("out_id", 32'(out_id), 32'(mon_e.id));
                    chk("out_data", 32'(out_data), 32'(mon_e.data));
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        in_valid  = '1;
        for (int i = 0; i < N; i++) in_data[i] = DW'(i);
        tick();
        tick();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_id", 32'(out_id), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        in_valid = '0;
        reset    = 1'b0;
        tick();

        // All requesters valid, sink always ready: ids rotate 0..3.
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = '1;
            #1;
            chk("t1_in_ready", 32'(in_ready), 32'(1 << (k % 4)));
            expect_word(k % 4, DW'(k % 4));
            tick();
        end
        in_valid = '0;
        tick();

        // Only requester 2 valid: accepted every cycle.
        in_data[2] = 16'hAAAA;
        for (int k = 0; k < 3; k++) begin
            in_valid = 4'b0100;
            #1;
            chk("t2_in_ready", 32'(in_ready), 32'h4);
            expect_word(2, 16'hAAAA);
            tick();
        end
        in_data[2] = 16'd2;
        // Pointer must now sit at 3: requester 3 wins over 0 and 1.
        in_valid = 4'b1011;
        #1;
        chk("t2_ptr_in_ready", 32'(in_ready), 32'h8);
        expect_word(3, 16'd3);
        tick();
        in_valid = '0;
        tick();
        tick();

        // Sink stalled: two words fill the buffer, third requester waits.
        out_ready = 1'b0;
        in_valid  = 4'b0111;
        #1;
        chk("t3_in_ready0", 32'(in_ready), 32'h1);
        expect_word(0, 16'd0);
        tick();
        in_valid = 4'b0110;
        #1;
        chk("t3_in_ready1", 32'(in_ready), 32'h2);
        expect_word(1, 16'd1);
        tick();
        in_valid = 4'b0100;
        #1;
        chk("t3_full_in_ready", 32'(in_ready), 32'h0);
        chk("t3_out_valid", 32'(out_valid), 32'h1);
        // out_ready toggling at full must not reach in_ready.
        out_ready = 1'b1;
        #1;
        chk("t6_comb_hi", 32'(in_ready), 32'h0);
        out_ready = 1'b0;
        #1;
        chk("t6_comb_lo", 32'(in_ready), 32'h0);
        tick();
        chk("t3_hold_id", 32'(out_id), 32'h0);
        chk("t3_hold_data", 32'(out_data), 32'h0);
        expect_word(2, 16'd2);
        out_ready = 1'b1;
        tick();
        #1;
        chk("t3_in_ready2", 32'(in_ready), 32'h4);
        tick();
        in_valid = '0;
        tick();
        chk("t3_drained", 32'(dq.size()), 32'h0);

        // Reset with a full buffer discards both words.
        out_ready = 1'b0;
        in_valid  = 4'b0011;
        tick();
        in_valid = 4'b0010;
        tick();
        in_valid = '0;
        chk("t5_full_valid", 32'(out_valid), 32'h1);
        reset    = 1'b1;
        in_valid = '1;
        #1;
        chk("t5_rst_in_ready_comb", 32'(in_ready), 32'h0);
        tick();
        chk("t5_rst_out_valid", 32'(out_valid), 32'h0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'h0);
        in_valid   = '0;
        reset      = 1'b0;
        in_data[1] = 16'h1234;
        out_ready  = 1'b1;
        in_valid   = 4'b0010;
        #1;
        chk("t5_in_ready", 32'(in_ready), 32'h2);
        expect_word(1, 16'h1234);
        tick();
        in_valid = '0;
        tick();
        tick();
        chk("t5_drained", 32'(dq.size()), 32'h0);

        // Random traffic: per-requester order, no loss, bounded wait.
        rand_mode = 1'b1;
        for (int i = 0; i < N; i++) begin
            seq[i]      = 0;
            wait_cnt[i] = 0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
                    in_valid[i] = 1'b1;
                    in_data[i]  = {2'(i), 14'(seq[i])};
                    rq[i].push_back({2'(i), 14'(seq[i])});
                    seq[i]++;
                end
            end
            #1;
            acc = in_valid & in_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    checks++;
                    if (wait_cnt[i] > int'(N - 1)) begin
                        errors++;
                        $display("FAIL rand_fair actual=%0d required<=%0d req=%0d", wait_cnt[i], N - 1, i);
                    end
                    wait_cnt[i] = 0;
                    in_valid[i] = 1'b0;
                end else if (in_valid[i] && acc != '0) begin
                    wait_cnt[i]++;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            while (!acc[i] && in_valid[i]) begin
                out_ready = 1'b1;
                #1;
                acc = in_valid & in_ready;
                tick();
                in_valid = in_valid & ~acc;
            end
        end
        in_valid  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        for (int i = 0; i < N; i++) begin
            chk("rand_left", 32'(rq[i].size()), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
